// File: rtl/fetch_iag_unit.sv
// Fetch-stage instruction address generator: next-PC select, bimodal/BTB/RAS
// prediction, per-ROB prediction records and commit-time predictor training.
package fetch_iag_pkg;
  typedef enum logic [0:0] {BP_BIMODAL = 1'b0, BP_STATIC = 1'b1} BrPredType_t;
endpackage

module fetch_iag_unit
  import fetch_iag_pkg::*;
#(
  parameter int          ADDR      = 32,
  parameter int          INST      = 32,
  parameter int          PRED_MAX  = 4,
  parameter int          BP_DEPTH  = 1024,
  parameter BrPredType_t PREDICTOR = BP_BIMODAL,
  parameter int          BTB_DEPTH = 64,
  parameter int          RA_DEPTH  = 8,
  parameter int          ROB_DEPTH = 32,
  parameter int          ROB       = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            fetch_stall_,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic            inst_e_,
  input  logic [ADDR-1:0] inst_pc,
  input  logic [INST-1:0] inst,
  input  logic            dec_e_,
  input  logic            dec_jr_,
  input  logic            dec_jump_,
  input  logic [ROB-1:0]  dec_rob_id,
  input  logic [ROB-1:0]  exe_rob_id,
  input  logic            wb_e_,
  input  logic [ROB-1:0]  wb_rob_id,
  input  logic            wb_pred_miss_,
  input  logic            wb_jump_miss_,
  input  logic            wb_br_result,
  input  logic [ADDR-1:0] wb_tar_addr,
  input  logic            commit_e_,
  input  logic [ADDR-1:0] commit_pc,
  input  logic [ROB-1:0]  com_rob_id,
  output logic [ADDR-1:0] next_fetch_pc,
  output logic            exe_br_pred,
  output logic [ADDR-1:0] exe_target,
  output logic            wb_flush_,
  output logic            busy
);

  localparam int BPI = $clog2(BP_DEPTH);
  localparam int BTI = $clog2(BTB_DEPTH);
  localparam int TAG = ADDR - 2 - BTI;
  localparam int RAP = $clog2(RA_DEPTH);
  localparam int FQP = $clog2(PRED_MAX);
  localparam logic [FQP:0] FQ_FULL = (FQP+1)'(PRED_MAX);

  logic [1:0]      r_bp_cnt   [BP_DEPTH];
  logic            r_btb_v    [BTB_DEPTH];
  logic [TAG-1:0]  r_btb_tag  [BTB_DEPTH];
  logic [ADDR-1:0] r_btb_tar  [BTB_DEPTH];
  logic [ADDR-1:0] r_ras      [RA_DEPTH];
  logic [RAP-1:0]  r_ras_ptr;
  logic            r_fq_pred  [PRED_MAX];
  logic [ADDR-1:0] r_fq_tar   [PRED_MAX];
  logic            r_fq_ret   [PRED_MAX];
  logic [FQP-1:0]  r_fq_wp, r_fq_rp;
  logic [FQP:0]    r_fq_cnt;
  logic            r_rec_pred [ROB_DEPTH];
  logic [ADDR-1:0] r_rec_tar  [ROB_DEPTH];
  logic            r_rec_jr   [ROB_DEPTH];
  logic            r_rec_ret  [ROB_DEPTH];
  logic            r_out_tkn  [ROB_DEPTH];
  logic [ADDR-1:0] r_out_tar  [ROB_DEPTH];

  logic [6:0]      w_opc;
  logic [4:0]      w_rd, w_rs1;
  logic            w_is_jal, w_is_jalr, w_is_br, w_is_ret, w_ctrl;
  logic            w_rd_link, w_rs1_link;
  logic [ADDR-1:0] w_j_imm, w_b_imm, w_seq_pc, w_ras_top;
  logic [RAP-1:0]  w_ras_top_ptr;
  logic [BTI-1:0]  w_btb_idx;
  logic            w_btb_hit;
  logic            w_pred;
  logic [ADDR-1:0] w_pred_tar;
  logic            w_flush;
  logic            w_fq_empty, w_fq_full, w_fq_push, w_fq_pop;
  logic [FQP-1:0]  w_fq_wp_nxt, w_fq_rp_nxt;
  logic [BPI-1:0]  w_com_bpi;
  logic [BTI-1:0]  w_com_bti;
  logic            w_com_btb;
  logic            w_unused;

  assign w_opc      = inst[6:0];
  assign w_rd       = inst[11:7];
  assign w_rs1      = inst[19:15];
  assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
  assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
  assign w_is_jal   = !inst_e_ && (w_opc == 7'b1101111);
  assign w_is_jalr  = !inst_e_ && (w_opc == 7'b1100111) && (inst[14:12] == 3'b000);
  assign w_is_br    = !inst_e_ && (w_opc == 7'b1100011);
  assign w_is_ret   = w_is_jalr && w_rs1_link && (w_rd == 5'd0);
  assign w_ctrl     = w_is_jal || w_is_jalr || w_is_br;

  assign w_j_imm  = {{(ADDR-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_b_imm  = {{(ADDR-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_seq_pc = inst_pc + ADDR'(4);

  // An empty stack reads the slot just below pointer 0, i.e. the last slot.
  assign w_ras_top_ptr = r_ras_ptr - RAP'(1);
  assign w_ras_top     = r_ras[w_ras_top_ptr];

  assign w_btb_idx = inst_pc[2 +: BTI];
  assign w_btb_hit = r_btb_v[w_btb_idx] && (r_btb_tag[w_btb_idx] == inst_pc[ADDR-1 -: TAG]);

  always_comb begin
    w_pred     = 1'b0;
    w_pred_tar = w_seq_pc;
    if (w_is_jal) begin
      w_pred     = 1'b1;
      w_pred_tar = inst_pc + w_j_imm;
    end else if (w_is_ret) begin
      w_pred     = 1'b1;
      w_pred_tar = w_ras_top;
    end else if (w_is_jalr) begin
      if (w_btb_hit) begin
        w_pred     = 1'b1;
        w_pred_tar = r_btb_tar[w_btb_idx];
      end
    end else if (w_is_br) begin
      w_pred     = (PREDICTOR == BP_BIMODAL) ? r_bp_cnt[inst_pc[2 +: BPI]][1] : 1'b0;
      w_pred_tar = inst_pc + w_b_imm;
    end
  end

  assign w_flush   = !wb_e_ && (!wb_pred_miss_ || !wb_jump_miss_);
  assign wb_flush_ = !w_flush;

  always_comb begin
    next_fetch_pc = fetch_pc + ADDR'(4);
    if (w_flush)
      next_fetch_pc = wb_tar_addr;
    else if (!fetch_stall_)
      next_fetch_pc = fetch_pc;
    else if (w_ctrl && w_pred)
      next_fetch_pc = w_pred_tar;
  end

  assign w_fq_empty  = (r_fq_cnt == '0);
  assign w_fq_full   = (r_fq_cnt == FQ_FULL);
  assign w_fq_pop    = !dec_e_ && !w_fq_empty;
  assign w_fq_push   = w_ctrl && (!w_fq_full || w_fq_pop);
  assign w_fq_wp_nxt = (r_fq_wp == FQP'(PRED_MAX-1)) ? '0 : r_fq_wp + FQP'(1);
  assign w_fq_rp_nxt = (r_fq_rp == FQP'(PRED_MAX-1)) ? '0 : r_fq_rp + FQP'(1);
  assign busy        = w_fq_full;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_fq_wp  <= '0;
      r_fq_rp  <= '0;
      r_fq_cnt <= '0;
      for (int i = 0; i < PRED_MAX; i++) begin
        r_fq_pred[i] <= 1'b0;
        r_fq_tar[i]  <= '0;
        r_fq_ret[i]  <= 1'b0;
      end
    end else if (w_flush) begin
      r_fq_wp  <= '0;
      r_fq_rp  <= '0;
      r_fq_cnt <= '0;
    end else begin
      if (w_fq_push) begin
        r_fq_pred[r_fq_wp] <= w_pred;
        r_fq_tar[r_fq_wp]  <= w_pred_tar;
        r_fq_ret[r_fq_wp]  <= w_is_ret;
        r_fq_wp            <= w_fq_wp_nxt;
      end
      if (w_fq_pop)
        r_fq_rp <= w_fq_rp_nxt;
      if (w_fq_push && !w_fq_pop)
        r_fq_cnt <= r_fq_cnt + 1'b1;
      else if (!w_fq_push && w_fq_pop)
        r_fq_cnt <= r_fq_cnt - 1'b1;
    end
  end

  // Return stack is not repaired on a flush; speculative push/pop stays in effect.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_ras_ptr <= '0;
      for (int i = 0; i < RA_DEPTH; i++)
        r_ras[i] <= '0;
    end else if (!w_flush) begin
      if (w_is_jal && w_rd_link) begin
        r_ras[r_ras_ptr] <= w_seq_pc;
        r_ras_ptr        <= r_ras_ptr + RAP'(1);
      end else if (w_is_ret) begin
        r_ras_ptr <= w_ras_top_ptr;
      end
    end
  end

  assign w_com_bpi = commit_pc[2 +: BPI];
  assign w_com_bti = commit_pc[2 +: BTI];
  assign w_com_btb = r_rec_jr[com_rob_id] && !r_rec_ret[com_rob_id];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < BP_DEPTH; i++)
        r_bp_cnt[i] <= 2'b01;
    end else if (!commit_e_ && (PREDICTOR == BP_BIMODAL)) begin
      if (r_out_tkn[com_rob_id]) begin
        if (r_bp_cnt[w_com_bpi] != 2'b11)
          r_bp_cnt[w_com_bpi] <= r_bp_cnt[w_com_bpi] + 2'b01;
      end else if (r_bp_cnt[w_com_bpi] != 2'b00) begin
        r_bp_cnt[w_com_bpi] <= r_bp_cnt[w_com_bpi] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_btb_v[i]   <= 1'b0;
        r_btb_tag[i] <= '0;
        r_btb_tar[i] <= '0;
      end
    end else if (!commit_e_ && w_com_btb) begin
      r_btb_v[w_com_bti]   <= 1'b1;
      r_btb_tag[w_com_bti] <= commit_pc[ADDR-1 -: TAG];
      r_btb_tar[w_com_bti] <= r_out_tar[com_rob_id];
    end
  end

  // Commit retires the slot's record; a decode into the same slot lands last and wins.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rec_pred[i] <= 1'b0;
        r_rec_tar[i]  <= '0;
        r_rec_jr[i]   <= 1'b0;
        r_rec_ret[i]  <= 1'b0;
        r_out_tkn[i]  <= 1'b0;
        r_out_tar[i]  <= '0;
      end
    end else begin
      if (!commit_e_) begin
        r_rec_pred[com_rob_id] <= 1'b0;
        r_rec_tar[com_rob_id]  <= '0;
        r_rec_jr[com_rob_id]   <= 1'b0;
        r_rec_ret[com_rob_id]  <= 1'b0;
      end
      if (!dec_e_) begin
        r_rec_pred[dec_rob_id] <= w_fq_pop ? r_fq_pred[r_fq_rp] : 1'b0;
        r_rec_tar[dec_rob_id]  <= w_fq_pop ? r_fq_tar[r_fq_rp] : '0;
        r_rec_ret[dec_rob_id]  <= w_fq_pop ? r_fq_ret[r_fq_rp] : 1'b0;
        r_rec_jr[dec_rob_id]   <= !dec_jr_;
      end
      if (!wb_e_) begin
        r_out_tkn[wb_rob_id] <= wb_br_result;
        r_out_tar[wb_rob_id] <= wb_tar_addr;
      end
    end
  end

  assign exe_br_pred = r_rec_pred[exe_rob_id];
  assign exe_target  = r_rec_tar[exe_rob_id];

  assign w_unused = &{1'b0, dec_jump_, commit_pc[1:0]};

endmodule

// File: tb/tb_fetch_iag_unit.sv
// Directed bench for fetch_iag_unit: next-PC select, RAS, BTB, bimodal training,
// prediction FIFO and ROB records, with hand-computed expectations.
module tb_fetch_iag_unit;

  logic        clk = 1'b0;
  logic        reset_;
  logic        fetch_stall_;
  logic [31:0] fetch_pc;
  logic        inst_e_;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        dec_e_, dec_jr_, dec_jump_;
  logic [4:0]  dec_rob_id, exe_rob_id, wb_rob_id, com_rob_id;
  logic        wb_e_, wb_pred_miss_, wb_jump_miss_, wb_br_result;
  logic [31:0] wb_tar_addr;
  logic        commit_e_;
  logic [31:0] commit_pc;
  logic [31:0] next_fetch_pc;
  logic        exe_br_pred;
  logic [31:0] exe_target;
  logic        wb_flush_;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] q_exp [4];

  localparam logic [31:0] I_JAL_RA  = 32'h040000EF;
  localparam logic [31:0] I_RET     = 32'h00008067;
  localparam logic [31:0] I_JR_X2   = 32'h00010067;
  localparam logic [31:0] I_BEQ_P20 = 32'h02000063;
  localparam logic [31:0] I_BEQ_M8  = 32'hFE000CE3;

  fetch_iag_unit dut (
    .clk(clk), .reset_(reset_), .fetch_stall_(fetch_stall_), .fetch_pc(fetch_pc),
    .inst_e_(inst_e_), .inst_pc(inst_pc), .inst(inst),
    .dec_e_(dec_e_), .dec_jr_(dec_jr_), .dec_jump_(dec_jump_), .dec_rob_id(dec_rob_id),
    .exe_rob_id(exe_rob_id), .wb_e_(wb_e_), .wb_rob_id(wb_rob_id),
    .wb_pred_miss_(wb_pred_miss_), .wb_jump_miss_(wb_jump_miss_),
    .wb_br_result(wb_br_result), .wb_tar_addr(wb_tar_addr),
    .commit_e_(commit_e_), .commit_pc(commit_pc), .com_rob_id(com_rob_id),
    .next_fetch_pc(next_fetch_pc), .exe_br_pred(exe_br_pred), .exe_target(exe_target),
    .wb_flush_(wb_flush_), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_stall_  = 1'b1;
    inst_e_       = 1'b1;
    dec_e_        = 1'b1;
    dec_jr_       = 1'b1;
    dec_jump_     = 1'b1;
    wb_e_         = 1'b1;
    wb_pred_miss_ = 1'b1;
    wb_jump_miss_ = 1'b1;
    wb_br_result  = 1'b0;
    commit_e_     = 1'b1;
  endtask

  task automatic pdec(input logic [31:0] pc, input logic [31:0] ins);
    inst_e_  = 1'b0;
    inst_pc  = pc;
    inst     = ins;
    fetch_pc = pc;
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    pdec(pc, ins);
    step();
    inst_e_ = 1'b1;
  endtask

  task automatic dec(input logic [4:0] rob, input logic jr);
    dec_e_     = 1'b0;
    dec_jr_    = !jr;
    dec_rob_id = rob;
    step();
    dec_e_  = 1'b1;
    dec_jr_ = 1'b1;
  endtask

  task automatic rd_rec(input logic [4:0] rob);
    exe_rob_id = rob;
    #1;
  endtask

  task automatic wb(input logic [4:0] rob, input logic tkn, input logic [31:0] tar, input logic jmiss);
    wb_e_         = 1'b0;
    wb_rob_id     = rob;
    wb_br_result  = tkn;
    wb_tar_addr   = tar;
    wb_jump_miss_ = !jmiss;
    step();
    idle();
  endtask

  task automatic commit(input logic [4:0] rob, input logic [31:0] pc);
    commit_e_  = 1'b0;
    com_rob_id = rob;
    commit_pc  = pc;
    step();
    commit_e_ = 1'b1;
  endtask

  task automatic flush_cyc();
    wb_e_         = 1'b0;
    wb_rob_id     = 5'd20;
    wb_pred_miss_ = 1'b0;
    wb_tar_addr   = 32'h0;
    step();
    idle();
  endtask

  initial begin
    idle();
    reset_ = 1'b0;
    fetch_pc = 32'h100; inst_pc = '0; inst = '0;
    dec_rob_id = '0; exe_rob_id = '0; wb_rob_id = '0; com_rob_id = '0;
    wb_tar_addr = '0; commit_pc = '0;
    q_exp[0] = 32'h630; q_exp[1] = 32'h640; q_exp[2] = 32'h650; q_exp[3] = 32'h720;
    repeat (2) step();
    reset_ = 1'b1;
    step();

    chk_eq("rst_next_pc", next_fetch_pc, 32'h104);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_flush_n", wb_flush_, 1);
    chk_eq("rst_exe_pred", exe_br_pred, 0);
    chk_eq("rst_exe_tar", exe_target, 0);

    pdec(32'h200, I_JAL_RA);
    chk_eq("jal_target", next_fetch_pc, 32'h240);
    step(); inst_e_ = 1'b1;
    pdec(32'h240, I_RET);
    chk_eq("ret_target", next_fetch_pc, 32'h204);
    step(); inst_e_ = 1'b1;

    dec(5'd1, 1'b0);
    dec(5'd2, 1'b1);
    rd_rec(5'd1);
    chk_eq("rec1_pred", exe_br_pred, 1);
    chk_eq("rec1_tar", exe_target, 32'h240);
    rd_rec(5'd2);
    chk_eq("rec2_pred", exe_br_pred, 1);
    chk_eq("rec2_tar", exe_target, 32'h204);
    dec(5'd1, 1'b0);
    rd_rec(5'd1);
    chk_eq("rec_empty_pred", exe_br_pred, 0);
    chk_eq("rec_empty_tar", exe_target, 0);

    wb_e_ = 1'b0; wb_rob_id = 5'd20; wb_pred_miss_ = 1'b0; wb_tar_addr = 32'h80;
    fetch_stall_ = 1'b0; fetch_pc = 32'h400;
    #1;
    chk_eq("flush_pred_n", wb_flush_, 0);
    chk_eq("flush_next_pc", next_fetch_pc, 32'h80);
    wb_pred_miss_ = 1'b1; wb_jump_miss_ = 1'b0;
    #1;
    chk_eq("flush_jump_n", wb_flush_, 0);
    wb_jump_miss_ = 1'b1;
    #1;
    chk_eq("noflush_n", wb_flush_, 1);
    chk_eq("stall_next_pc", next_fetch_pc, 32'h400);
    idle();

    for (int k = 0; k < 4; k++) begin
      pdec(32'h600 + 32'(k * 16), I_BEQ_P20);
      if (k == 0) chk_eq("br_nt_next_pc", next_fetch_pc, 32'h604);
      step(); inst_e_ = 1'b1;
      if (k == 2) chk_eq("busy_at3", busy, 0);
    end
    chk_eq("busy_full", busy, 1);
    push(32'h640, I_BEQ_P20);
    chk_eq("busy_drop", busy, 1);
    dec(5'd4, 1'b0);
    chk_eq("busy_after_dec", busy, 0);
    rd_rec(5'd4);
    chk_eq("rec4_pred", exe_br_pred, 0);
    chk_eq("rec4_tar", exe_target, 32'h620);
    push(32'h700, I_BEQ_P20);
    chk_eq("busy_refill", busy, 1);
    for (int k = 0; k < 4; k++) begin
      dec(5'(8 + k), 1'b0);
      rd_rec(5'(8 + k));
      chk_eq($sformatf("fifo_order%0d", k), exe_target, q_exp[k]);
    end
    chk_eq("busy_drained", busy, 0);
    push(32'h600, I_BEQ_P20);
    flush_cyc();
    dec(5'd12, 1'b0);
    rd_rec(5'd12);
    chk_eq("flush_emptied", exe_target, 0);

    pdec(32'h300, I_BEQ_P20);
    chk_eq("bim_init_nt", next_fetch_pc, 32'h304);
    inst_e_ = 1'b1;
    wb(5'd5, 1'b1, 32'h320, 1'b0);
    commit(5'd5, 32'h300);
    pdec(32'h300, I_BEQ_P20);
    chk_eq("bim_wt_taken", next_fetch_pc, 32'h320);
    inst_e_ = 1'b1;
    commit(5'd5, 32'h300);
    pdec(32'h300, I_BEQ_P20);
    chk_eq("bim_st_taken", next_fetch_pc, 32'h320);
    pdec(32'h300, I_BEQ_M8);
    chk_eq("bim_neg_tar", next_fetch_pc, 32'h2F8);
    inst_e_ = 1'b1;
    commit(5'd5, 32'h300);
    wb(5'd5, 1'b0, 32'h304, 1'b0);
    commit(5'd5, 32'h300);
    pdec(32'h300, I_BEQ_P20);
    chk_eq("bim_sat_hi", next_fetch_pc, 32'h320);
    inst_e_ = 1'b1;
    commit(5'd5, 32'h300);
    pdec(32'h300, I_BEQ_P20);
    chk_eq("bim_back_nt", next_fetch_pc, 32'h304);
    inst_e_ = 1'b1;

    pdec(32'h500, I_JR_X2);
    chk_eq("btb_miss", next_fetch_pc, 32'h504);
    step(); inst_e_ = 1'b1;
    dec(5'd3, 1'b1);
    rd_rec(5'd3);
    chk_eq("rec3_tar", exe_target, 32'h504);
    wb(5'd3, 1'b1, 32'h900, 1'b1);
    commit(5'd3, 32'h500);
    pdec(32'h500, I_JR_X2);
    chk_eq("btb_hit", next_fetch_pc, 32'h900);
    pdec(32'h600, I_JR_X2);
    chk_eq("btb_tag_miss", next_fetch_pc, 32'h604);
    inst_e_ = 1'b1;

    for (int k = 0; k < 9; k++)
      push(32'h1000 + 32'(k * 16), I_JAL_RA);
    flush_cyc();
    pdec(32'h3000, I_RET);
    chk_eq("ras_wrap_top", next_fetch_pc, 32'h1084);
    step(); inst_e_ = 1'b1;
    pdec(32'h3000, I_RET);
    chk_eq("ras_empty_pop", next_fetch_pc, 32'h1074);
    step(); inst_e_ = 1'b1;

    flush_cyc();
    push(32'h600, I_BEQ_P20);
    dec_e_ = 1'b0; dec_rob_id = 5'd6;
    commit_e_ = 1'b0; com_rob_id = 5'd6; commit_pc = 32'h800;
    step();
    idle();
    rd_rec(5'd6);
    chk_eq("dec_over_commit", exe_target, 32'h620);

    for (int k = 0; k < 4; k++)
      push(32'h600, I_BEQ_P20);
    chk_eq("busy_pre_rst", busy, 1);
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    chk_eq("async_rst_busy", busy, 0);
    chk_eq("async_rst_rec", exe_target, 0);
    @(posedge clk);
    #1;
    reset_ = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
